// File: rtl/psum_pkg.sv
// Shared definitions for the psum packet collector: packet layout, FSM states
// and the saturating psum adder.
package psum_pkg;

  localparam int DST_LSB    = 43;
  localparam int SRC_LSB    = 39;
  localparam int TYPE_LSB   = 36;
  localparam int IDX_LSB    = 31;
  localparam int PKT_PSUM_W = 16;

  localparam logic [2:0] PKT_TYPE_PSUM = 3'b010;

  typedef struct packed {
    logic [3:0]            dst;
    logic [3:0]            src;
    logic [2:0]            ptype;
    logic [4:0]            idx;
    logic [14:0]           rsvd;
    logic [PKT_PSUM_W-1:0] psum;
  } psum_pkt_t;

  typedef enum logic [1:0] {CLEAR, RUN, EMIT} state_t;

  // One guard bit catches overflow; clamp to the signed range on disagreement.
  function automatic logic signed [PKT_PSUM_W-1:0] sat_add(
    input logic signed [PKT_PSUM_W-1:0] a,
    input logic signed [PKT_PSUM_W-1:0] b
  );
    logic signed [PKT_PSUM_W:0] s;
    s = {a[PKT_PSUM_W-1], a} + {b[PKT_PSUM_W-1], b};
    if (s[PKT_PSUM_W] != s[PKT_PSUM_W-1])
      return s[PKT_PSUM_W] ? {1'b1, {(PKT_PSUM_W-1){1'b0}}}
                           : {1'b0, {(PKT_PSUM_W-1){1'b1}}};
    return s[PKT_PSUM_W-1:0];
  endfunction

endpackage

// File: rtl/psum_pkt_collector_fifo.sv
// pkt_sync_fifo: small synchronous FIFO, valid/ready on the push side and
// pop/empty on the pull side. DEPTH must be a power of two.
module pkt_sync_fifo #(
  parameter int WIDTH = 47,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] pop_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Fullness comes from the registered count only: a same-cycle pop never frees a slot.
  assign push_ready = (count != (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign pop_data   = mem[rd_ptr];
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/psum_pkt_collector.sv
// Collects psum packets, accumulates NUM_PSUM contributions per output index
// and emits finished pixels. Define PSUM_COLLECTOR_RELU_EN to clip negative sums at emit.
module psum_pkt_collector
  import psum_pkg::*;
#(
  parameter int         PWIDTH     = 47,
  parameter int         DWIDTH     = 8,
  parameter int         PSUM_W     = 16,
  parameter int         NUM_OUT    = 25,
  parameter int         NUM_PSUM   = 5,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] MY_ADDR    = 4'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PWIDTH-1:0]        in_pkt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4:0]               out_idx,
  output logic signed [PSUM_W-1:0] out_sum,
  output logic                     frame_done,
  output logic [7:0]               err_cnt
);

  localparam int IDX_W = 5;
  localparam int CNT_W = $clog2(NUM_PSUM + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_OUT - 1);
  localparam logic [CNT_W-1:0] NUM_PSUM_C = CNT_W'(NUM_PSUM);
  localparam int UNUSED_DWIDTH = DWIDTH;

  state_t                   state;
  logic [IDX_W-1:0]         ptr;
  logic [IDX_W-1:0]         emit_cnt;
  logic signed [PSUM_W-1:0] acc [NUM_OUT];
  logic [CNT_W-1:0]         cnt [NUM_OUT];

  logic                     fifo_ready;
  logic                     fifo_empty;
  logic [PWIDTH-1:0]        fifo_head;

  logic                     pop_p0;
  psum_pkt_t                head_p0;
  logic                     ok_p0;
  logic signed [PSUM_W-1:0] sum_p0;
  logic [CNT_W-1:0]         cnt_p0;
  logic                     unused_fields;

  function automatic logic signed [PSUM_W-1:0] emit_val(input logic signed [PSUM_W-1:0] s);
`ifdef PSUM_COLLECTOR_RELU_EN
    return s[PSUM_W-1] ? '0 : s;
`else
    return s;
`endif
  endfunction

  assign in_ready = (state != CLEAR) && fifo_ready;

  pkt_sync_fifo #(
    .WIDTH (PWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_in_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (in_valid && (state != CLEAR)),
    .push_ready (fifo_ready),
    .push_data  (in_pkt),
    .pop        (pop_p0),
    .empty      (fifo_empty),
    .pop_data   (fifo_head)
  );

  // Stage p0: decode the FIFO head and form the candidate accumulator update.
  assign pop_p0        = (state == RUN) && !fifo_empty;
  assign head_p0       = fifo_head;
  assign ok_p0         = (head_p0.dst == MY_ADDR) && (head_p0.ptype == PKT_TYPE_PSUM) &&
                         (head_p0.idx <= LAST_IDX);
  assign sum_p0        = sat_add(acc[head_p0.idx], head_p0.psum);
  assign cnt_p0        = cnt[head_p0.idx] + 1'b1;
  assign unused_fields = ^{head_p0.src, head_p0.rsvd};

  // Stage p1: commit to the arrays and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= CLEAR;
      ptr        <= '0;
      emit_cnt   <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_sum    <= '0;
      frame_done <= 1'b0;
      err_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        CLEAR: begin
          acc[ptr] <= '0;
          cnt[ptr] <= '0;
          if (ptr == LAST_IDX) begin
            ptr   <= '0;
            state <= RUN;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        RUN: begin
          if (pop_p0) begin
            if (!ok_p0) begin
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
            end else if (cnt_p0 == NUM_PSUM_C) begin
              acc[head_p0.idx] <= '0;
              cnt[head_p0.idx] <= '0;
              out_idx          <= head_p0.idx;
              out_sum          <= emit_val(sum_p0);
              out_valid        <= 1'b1;
              state            <= EMIT;
            end else begin
              acc[head_p0.idx] <= sum_p0;
              cnt[head_p0.idx] <= cnt_p0;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= RUN;
            if (emit_cnt == LAST_IDX) begin
              emit_cnt   <= '0;
              frame_done <= 1'b1;
            end else begin
              emit_cnt <= emit_cnt + 1'b1;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_pkt_collector.sv
// Randomized bench for psum_pkt_collector with a queue-based reference model.
module tb_psum_pkt_collector;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [46:0]        in_pkt = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [4:0]         out_idx;
  logic signed [15:0] out_sum;
  logic               frame_done;
  logic [7:0]         err_cnt;

  psum_pkt_collector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pkt     (in_pkt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_sum    (out_sum),
    .frame_done (frame_done),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int macc [25];
  int mcnt [25];
  int exp_idx_q [$];
  int exp_sum_q [$];
  int memit = 0;
  int merr = 0;
  bit fd_exp = 1'b0;
  int emits_seen = 0;
  int fd_pulses = 0;
  int last_idx = -1;
  int last_sum = 0;
  int ordy_mode = 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 25; i++) begin
      macc[i] = 0;
      mcnt[i] = 0;
    end
    exp_idx_q.delete();
    exp_sum_q.delete();
    memit  = 0;
    merr   = 0;
    fd_exp = 1'b0;
  endtask

  task automatic model_accept(input logic [46:0] p);
    logic [3:0]         dst;
    logic [2:0]         ty;
    int                 ix;
    logic signed [15:0] ps16;
    int                 s;
    dst  = p[46:43];
    ty   = p[38:36];
    ix   = int'(p[35:31]);
    ps16 = p[15:0];
    if (dst != 4'h0 || ty != 3'b010 || ix >= 25) begin
      if (merr < 255) merr++;
    end else begin
      macc[ix] = clamp16(macc[ix] + int'(ps16));
      mcnt[ix]++;
      if (mcnt[ix] == 5) begin
        s = macc[ix];
`ifdef PSUM_COLLECTOR_RELU_EN
        if (s < 0) s = 0;
`endif
        exp_idx_q.push_back(ix);
        exp_sum_q.push_back(s);
        macc[ix] = 0;
        mcnt[ix] = 0;
      end
    end
  endtask

  // Model update: observe handshakes at the active edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      model_clear();
    end else begin
      fd_exp = 1'b0;
      if (out_valid && out_ready) begin
        emits_seen++;
        last_idx = int'(out_idx);
        last_sum = int'(out_sum);
        if (exp_idx_q.size() > 0) begin
          void'(exp_idx_q.pop_front());
          void'(exp_sum_q.pop_front());
        end
        memit++;
        if (memit == 25) begin
          memit  = 0;
          fd_exp = 1'b1;
        end
      end
      if (in_valid && in_ready) model_accept(in_pkt);
    end
  end

  // Compare process: outputs sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_out_sum", int'(out_sum), 0);
      check("reset_err_cnt", int'(err_cnt), 0);
      check("reset_in_ready", int'(in_ready), 0);
    end else begin
      check("frame_done", int'(frame_done), int'(fd_exp));
      if (frame_done) fd_pulses++;
      if (out_valid) begin
        check("emit_has_expectation", int'(exp_idx_q.size() > 0), 1);
        if (exp_idx_q.size() > 0) begin
          check("out_idx", int'(out_idx), exp_idx_q[0]);
          check("out_sum", int'(out_sum), exp_sum_q[0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    case (ordy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic send(input logic [3:0] dst, input logic [2:0] ty,
                      input logic [4:0] ix, input logic [15:0] ps);
    int t = 0;
    in_pkt   = {dst, 4'h1, ty, ix, 15'h0, ps};
    in_valid = 1'b1;
    while (!in_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("send_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_idx_q.size() != 0 || out_valid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) check("drain_timeout", 0, 1);
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      check("clear_in_ready", int'(in_ready), (i == 25) ? 1 : 0);
      if (i == 1) begin
        check("clear_out_valid", int'(out_valid), 0);
        check("clear_out_idx", int'(out_idx), 0);
        check("clear_frame_done", int'(frame_done), 0);
      end
    end
  endtask

  task automatic random_frame(input int npkts);
    int ids [125];
    int j;
    int tmp;
    for (int i = 0; i < 125; i++) ids[i] = i / 5;
    for (int i = 124; i > 0; i--) begin
      j       = $urandom_range(0, i);
      tmp     = ids[i];
      ids[i]  = ids[j];
      ids[j]  = tmp;
    end
    for (int i = 0; i < npkts; i++) begin
      if ($urandom_range(0, 7) == 0)
        send(4'h1, 3'b010, 5'(ids[i]), 16'($urandom_range(0, 65535)));
      send(4'h0, 3'b010, 5'(ids[i]), 16'($urandom_range(0, 65535)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Single index, mixed signs
    emits_seen = 0;
    send(4'h0, 3'b010, 5'd3, 16'd10);
    send(4'h0, 3'b010, 5'd3, 16'd20);
    send(4'h0, 3'b010, 5'd3, -16'sd5);
    send(4'h0, 3'b010, 5'd3, 16'd7);
    send(4'h0, 3'b010, 5'd3, 16'd1);
    drain();
    check("t2_emits", emits_seen, 1);
    check("t2_idx", last_idx, 3);
    check("t2_sum", last_sum, 33);
    for (int i = 0; i < 5; i++) send(4'h0, 3'b010, 5'd3, 16'd1);
    drain();
    check("t2_reuse_sum", last_sum, 5);

    // Saturation and sign handling
    for (int i = 0; i < 5; i++) send(4'h0, 3'b010, 5'd0, 16'h7FF0);
    drain();
    check("t3_sat_sum", last_sum, 32767);
    for (int i = 0; i < 5; i++) send(4'h0, 3'b010, 5'd1, -16'sd100);
    drain();
`ifdef PSUM_COLLECTOR_RELU_EN
    check("t3_neg_sum", last_sum, 0);
`else
    check("t3_neg_sum", last_sum, -500);
`endif

    // Dropped packets
    emits_seen = 0;
    send(4'h2, 3'b010, 5'd4, 16'd1);
    send(4'h0, 3'b001, 5'd4, 16'd1);
    send(4'h0, 3'b010, 5'd30, 16'd1);
    drain();
    check("t4_err_cnt", int'(err_cnt), 3);
    check("t4_model_err", merr, 3);
    check("t4_in_ready", int'(in_ready), 1);
    check("t4_emits", emits_seen, 0);

    // Back-pressure while an emit is held
    emits_seen = 0;
    ordy_mode  = 0;
    for (int i = 0; i < 5; i++) send(4'h0, 3'b010, 5'd5, 16'd2);
    begin
      int t = 0;
      while (!out_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("t5_emit_seen", int'(out_valid), 1);
    end
    for (int i = 0; i < 4; i++) send(4'h0, 3'b010, 5'd6, 16'd3);
    check("t5_full_in_ready", int'(in_ready), 0);
    in_pkt   = {4'h0, 4'h1, 3'b010, 5'd6, 15'h0, 16'd3};
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_hold_in_ready", int'(in_ready), 0);
      check("t5_hold_out_sum", int'(out_sum), 10);
    end
    ordy_mode = 1;
    send(4'h0, 3'b010, 5'd6, 16'd3);
    send(4'h0, 3'b010, 5'd7, 16'd9);
    drain();
    check("t5_emits", emits_seen, 2);
    check("t5_last_idx", last_idx, 6);
    check("t5_last_sum", last_sum, 15);

    // Full random frame
    do_reset();
    emits_seen = 0;
    fd_pulses  = 0;
    ordy_mode  = 2;
    random_frame(125);
    drain();
    check("t6_emits", emits_seen, 25);
    check("t6_frame_done", fd_pulses, 1);
    check("t6_err_cnt", int'(err_cnt), merr);

    // Reset mid-frame, then a clean frame
    do_reset();
    random_frame(60);
    do_reset();
    emits_seen = 0;
    fd_pulses  = 0;
    random_frame(125);
    drain();
    check("t6b_emits", emits_seen, 25);
    check("t6b_frame_done", fd_pulses, 1);
    check("t6b_err_cnt", int'(err_cnt), merr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
